// File: rtl/usr_cfg_pkg.sv
// Shared constants and helpers for the usr_cfg register responder.
package usr_cfg_pkg;

  localparam logic BANK_CTRL = 1'b0;
  localparam logic BANK_STS  = 1'b1;

  // Wide enough for any supported data width; users slice the low bits.
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam logic [MAX_DATA_WIDTH-1:0] UNMAPPED_RD_VAL = '1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/usr_cfg_rd_pipe.sv
// Fixed-latency valid/data delay line for the usr_cfg read return path.
module usr_cfg_rd_pipe #(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic [LAT-1:0] r_vld;
  logic [W-1:0]   r_data [LAT];

  // NOTE: sequential state uses <= only, so every stage samples the pre-edge value of the one before it.
  // NOTE: the data stages are reset (not just the valids) because o_data must read zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
      for (int k = 0; k < LAT; k++) r_data[k] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) r_data[0] <= i_data;
      // Data only moves with its valid, so the last stage holds between reads.
      for (int k = 1; k < LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_vld  = r_vld[LAT-1];
  assign o_data = r_data[LAT-1];

endmodule

// File: rtl/usr_cfg_regs.sv
// usr_cfg bus responder: control register bank, status bank, pipelined read return.
// Define USR_CFG_RD_CLR_EN for sticky read-to-clear status latches.
module usr_cfg_regs
  import usr_cfg_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 32,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned REG_NUM        = 16,
  parameter int unsigned RD_LAT         = 2,
  parameter logic [REG_DATA_WIDTH-1:0] CFG_RST_VAL = '0
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                usr_cfg_type,
  input  logic                                usr_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]           usr_wr_addr,
  input  logic [REG_DATA_WIDTH-1:0]           usr_wr_data,
  input  logic                                usr_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0]           usr_rd_addr,
  output logic                                usr_rd_vld,
  output logic [REG_DATA_WIDTH-1:0]           usr_rd_data,
  output logic [REG_NUM*REG_DATA_WIDTH-1:0]   cfg_regs,
  output logic [REG_NUM-1:0]                  cfg_wr_pulse,
  input  logic [REG_NUM*REG_DATA_WIDTH-1:0]   sts_in,
  output logic                                cfg_err,
  input  logic                                cfg_err_clr
);

  localparam int unsigned IDX_W = clog2(REG_NUM);
  localparam logic [REG_DATA_WIDTH-1:0] UNMAPPED_VAL = UNMAPPED_RD_VAL[REG_DATA_WIDTH-1:0];

  logic [REG_DATA_WIDTH-1:0] r_cfg [REG_NUM];
  logic [REG_NUM-1:0]        r_wr_pulse;
  logic                      r_err;

  logic [REG_DATA_WIDTH-1:0] w_sts_in [REG_NUM];
  logic [REG_DATA_WIDTH-1:0] w_sts_val;
  logic [REG_DATA_WIDTH-1:0] w_rd_data;
  logic [IDX_W-1:0]          w_wr_idx;
  logic [IDX_W-1:0]          w_rd_idx;
  logic                      w_wr_mapped;
  logic                      w_rd_mapped;
  logic                      w_wr_ok;
  logic                      w_err_set;

  assign w_wr_idx    = usr_wr_addr[IDX_W-1:0];
  assign w_rd_idx    = usr_rd_addr[IDX_W-1:0];
  assign w_wr_mapped = usr_wr_addr < REG_ADDR_WIDTH'(REG_NUM);
  assign w_rd_mapped = usr_rd_addr < REG_ADDR_WIDTH'(REG_NUM);
  assign w_wr_ok     = usr_wr_en && w_wr_mapped && (usr_cfg_type == BANK_CTRL);
  assign w_err_set   = (usr_wr_en && !w_wr_ok) || (usr_rd_en && !w_rd_mapped);

  for (genvar i = 0; i < REG_NUM; i++) begin : g_flat
    assign cfg_regs[i*REG_DATA_WIDTH +: REG_DATA_WIDTH] = r_cfg[i];
    assign w_sts_in[i] = sts_in[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_NUM; i++) r_cfg[i] <= CFG_RST_VAL;
      r_wr_pulse <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_pulse <= '0;
      if (w_wr_ok) begin
        r_cfg[w_wr_idx]      <= usr_wr_data;
        r_wr_pulse[w_wr_idx] <= 1'b1;
      end
      if (w_err_set)        r_err <= 1'b1;
      else if (cfg_err_clr) r_err <= 1'b0;
    end
  end

`ifdef USR_CFG_RD_CLR_EN
  logic [REG_DATA_WIDTH-1:0] r_sts [REG_NUM];
  logic                      w_sts_clr;

  assign w_sts_clr = usr_rd_en && w_rd_mapped && (usr_cfg_type == BANK_STS);

  // A live sts_in bit wins over the read-clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_NUM; i++) r_sts[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (w_sts_clr && (w_rd_idx == IDX_W'(i))) r_sts[i] <= w_sts_in[i];
        else                                      r_sts[i] <= r_sts[i] | w_sts_in[i];
      end
    end
  end

  assign w_sts_val = r_sts[w_rd_idx];
`else
  assign w_sts_val = w_sts_in[w_rd_idx];
`endif

  // NOTE: default first so every path assigns w_rd_data and no latch is inferred.
  always_comb begin
    w_rd_data = UNMAPPED_VAL;
    if (w_rd_mapped) w_rd_data = (usr_cfg_type == BANK_CTRL) ? r_cfg[w_rd_idx] : w_sts_val;
  end

  usr_cfg_rd_pipe #(
    .LAT (RD_LAT),
    .W   (REG_DATA_WIDTH)
  ) u_rd_pipe (
    .clk    (clk),
    .rstn   (rstn),
    .i_vld  (usr_rd_en),
    .i_data (w_rd_data),
    .o_vld  (usr_rd_vld),
    .o_data (usr_rd_data)
  );

  assign cfg_wr_pulse = r_wr_pulse;
  assign cfg_err      = r_err;

endmodule

// File: tb/tb_usr_cfg_regs.sv
// Scoreboard bench for usr_cfg_regs; two instances cover read latencies 2 and 3.
module tb_usr_cfg_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic           cfg_type = 1'b0;
  logic           wr_en    = 1'b0;
  logic [AW-1:0]  wr_addr  = '0;
  logic [DW-1:0]  wr_data  = '0;
  logic           rd_en    = 1'b0;
  logic [AW-1:0]  rd_addr  = '0;
  logic [NR*DW-1:0] sts_in = '0;
  logic           err_clr  = 1'b0;

  logic           vld2, vld3, err2, err3;
  logic [DW-1:0]  data2, data3;
  logic [NR*DW-1:0] regs2, regs3;
  logic [NR-1:0]  pulse2, pulse3;

  usr_cfg_regs #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .REG_NUM(NR), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .usr_cfg_type(cfg_type),
    .usr_wr_en(wr_en), .usr_wr_addr(wr_addr), .usr_wr_data(wr_data),
    .usr_rd_en(rd_en), .usr_rd_addr(rd_addr),
    .usr_rd_vld(vld2), .usr_rd_data(data2),
    .cfg_regs(regs2), .cfg_wr_pulse(pulse2), .sts_in(sts_in),
    .cfg_err(err2), .cfg_err_clr(err_clr)
  );

  usr_cfg_regs #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .REG_NUM(NR), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .usr_cfg_type(cfg_type),
    .usr_wr_en(wr_en), .usr_wr_addr(wr_addr), .usr_wr_data(wr_data),
    .usr_rd_en(rd_en), .usr_rd_addr(rd_addr),
    .usr_rd_vld(vld3), .usr_rd_data(data3),
    .cfg_regs(regs3), .cfg_wr_pulse(pulse3), .sts_in(sts_in),
    .cfg_err(err3), .cfg_err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  typedef struct packed {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;

  // One bus cycle: drive at the falling edge, return at the next falling edge.
  task automatic op(input logic we, input logic re, input logic typ,
                    input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic [AW-1:0] ra, input logic [DW-1:0] exp_rd);
    wr_en    = we;
    rd_en    = re;
    cfg_type = typ;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr  = ra;
    if (re) begin
      q2.push_back('{data: exp_rd, due: cyc + 2});
      q3.push_back('{data: exp_rd, due: cyc + 3});
    end
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (vld2) begin
      if (q2.size() == 0) check("rd2_spurious_vld", 64'(1), 64'(0));
      else begin
        e2 = q2.pop_front();
        check("rd2_data", 64'(data2), 64'(e2.data));
        check("rd2_latency", 64'(cyc), 64'(e2.due));
      end
    end else if (q2.size() > 0 && q2[0].due < cyc) begin
      check("rd2_timeout", 64'(0), 64'(1));
      void'(q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (vld3) begin
      if (q3.size() == 0) check("rd3_spurious_vld", 64'(1), 64'(0));
      else begin
        e3 = q3.pop_front();
        check("rd3_data", 64'(data3), 64'(e3.data));
        check("rd3_latency", 64'(cyc), 64'(e3.due));
      end
    end else if (q3.size() > 0 && q3[0].due < cyc) begin
      check("rd3_timeout", 64'(0), 64'(1));
      void'(q3.pop_front());
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld2"},  64'(vld2), 64'(0));
    check({tag, "_vld3"},  64'(vld3), 64'(0));
    check({tag, "_data2"}, 64'(data2), 64'(0));
    check({tag, "_data3"}, 64'(data3), 64'(0));
    check({tag, "_regs"},  64'(regs2 == '0 && regs3 == '0), 64'(1));
    check({tag, "_pulse"}, 64'({pulse2, pulse3}), 64'(0));
    check({tag, "_err"},   64'({err2, err3}), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;

    // Write reg 3, observe register and one-cycle pulse.
    op(1'b1, 1'b0, 1'b0, 32'd3, 32'h1234_5678, '0, '0);
    check("wr3_reg", 64'(reg_of(regs2, 3)), 64'h1234_5678);
    check("wr3_pulse", 64'(pulse2), 64'h0008);
    check("wr3_pulse_lat3", 64'(pulse3), 64'h0008);
    idle();
    check("wr3_pulse_drop", 64'(pulse2), 64'h0000);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd3, 32'h1234_5678);

    // Same-cycle write and read of reg 5 returns the old value.
    op(1'b1, 1'b1, 1'b0, 32'd5, 32'hA5A5_A5A5, 32'd5, 32'h0);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd5, 32'hA5A5_A5A5);

    // Back-to-back reads of regs 0..3 plus the top mapped register.
    op(1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0011, '0, '0);
    op(1'b1, 1'b0, 1'b0, 32'd1, 32'h0000_0022, '0, '0);
    op(1'b1, 1'b0, 1'b0, 32'd2, 32'h0000_0033, '0, '0);
    op(1'b1, 1'b0, 1'b0, 32'd15, 32'hFEED_000F, '0, '0);
    check("wr15_pulse", 64'(pulse2), 64'h8000);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd0, 32'h0000_0011);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd1, 32'h0000_0022);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd2, 32'h0000_0033);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd3, 32'h1234_5678);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd15, 32'hFEED_000F);
    check("legal_no_err", 64'({err2, err3}), 64'(0));

    // Status-bank write is dropped and flags an error.
    op(1'b1, 1'b0, 1'b1, 32'd2, 32'hDEAD_BEEF, '0, '0);
    check("wr_sts_err", 64'(err2), 64'(1));
    check("wr_sts_dropped", 64'(reg_of(regs2, 2)), 64'h0000_0033);
    check("wr_sts_no_pulse", 64'(pulse2), 64'(0));
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd20, 32'hFFFF_FFFF);
    check("rd20_err_held", 64'(err2), 64'(1));
    err_clr = 1'b1;
    idle();
    check("err_cleared", 64'({err2, err3}), 64'(0));

    // Unmapped write at REG_NUM with a simultaneous clear: set wins.
    err_clr = 1'b1;
    op(1'b1, 1'b0, 1'b0, 32'd16, 32'h0000_0001, '0, '0);
    check("err_set_wins", 64'(err2), 64'(1));
    check("wr16_dropped", 64'(reg_of(regs2, 0)), 64'h0000_0011);
    err_clr = 1'b1;
    idle();
    check("err_cleared2", 64'(err2), 64'(0));
    op(1'b0, 1'b1, 1'b1, '0, '0, 32'd16, 32'hFFFF_FFFF);
    check("rd16_sts_err", 64'(err2), 64'(1));
    err_clr = 1'b1;
    idle();

    // Status bank reads.
`ifdef USR_CFG_RD_CLR_EN
    sts_in[1*DW +: DW] = 32'h0000_0001;
    idle();
    sts_in = '0;
    op(1'b0, 1'b1, 1'b1, '0, '0, 32'd1, 32'h0000_0001);
    op(1'b0, 1'b1, 1'b1, '0, '0, 32'd1, 32'h0000_0000);
`else
    sts_in[1*DW +: DW] = 32'hCAFE_0001;
    op(1'b0, 1'b1, 1'b1, '0, '0, 32'd1, 32'hCAFE_0001);
    sts_in[1*DW +: DW] = 32'h0000_1234;
    op(1'b0, 1'b1, 1'b1, '0, '0, 32'd1, 32'h0000_1234);
    sts_in = '0;
`endif
    check("sts_rd_no_err", 64'(err2), 64'(0));
    repeat (5) idle();

    // Reset with reads in flight: nothing may emerge afterwards.
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd3, 32'h1234_5678);
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd5, 32'hA5A5_A5A5);
    #1;
    rstn = 1'b0;
    q2.delete();
    q3.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("post_rst_no_vld", 64'({vld2, vld3}), 64'(0));
    end
    op(1'b0, 1'b1, 1'b0, '0, '0, 32'd3, 32'h0);

    for (int i = 0; i < 10 && (q2.size() > 0 || q3.size() > 0); i++) idle();
    check("scoreboard_drained", 64'(q2.size() + q3.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
